// File: rtl/frog_log_carry.sv
// rtl/frog_log_carry.sv - frog position keeper: hops, log carry, drown/off-screen death
// Optional feature macro: FROG_LIVES_EN (finite lives, game-over state).
// Ports:
//   frame_clk, Reset_n          clock, asynchronous active-low reset
//   hop_up/down/left/right      single-cycle hop request pulses
//   logX_bus, logY_bus          packed 10-bit log positions, log i at [10*i+9:10*i]
//   log_moved                   bit i: log i advanced +1 px this cycle
//   frogX, frogY                registered frog position
//   riding                      frog in river rows and over a log
//   dying, dead                 DYING flag, one-cycle pulse on ALIVE->DYING
//   lives, game_over            remaining lives, sticky game-over
module frog_log_carry #(
  parameter int NUM_LOGS   = 4,
  parameter int LOG_W      = 48,
  parameter int FROG_W     = 16,
  parameter int STEP       = 16,
  parameter int X_MIN      = 159,
  parameter int X_MAX      = 463,
  parameter int Y_MIN      = 32,
  parameter int Y_MAX      = 448,
  parameter int RIVER_TOP  = 96,
  parameter int RIVER_BOT  = 224,
  parameter int START_X    = 304,
  parameter int START_Y    = 448,
  parameter int DEATH_HOLD = 50000000
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic                  hop_up,
  input  logic                  hop_down,
  input  logic                  hop_left,
  input  logic                  hop_right,
  input  logic [10*NUM_LOGS-1:0] logX_bus,
  input  logic [10*NUM_LOGS-1:0] logY_bus,
  input  logic [NUM_LOGS-1:0]   log_moved,
  output logic [9:0]            frogX,
  output logic [9:0]            frogY,
  output logic                  riding,
  output logic                  dying,
  output logic                  dead,
  output logic [1:0]            lives,
  output logic                  game_over
);

  typedef enum logic [1:0] {S_ALIVE, S_DYING, S_OVER} state_t;

  localparam int CNT_W = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_HOLD - 1);

  // 11-bit constants so overlap / boundary sums never wrap
  localparam logic [10:0] LOG_W11  = 11'(LOG_W);
  localparam logic [10:0] FROG_W11 = 11'(FROG_W);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [10:0] X_MIN11  = 11'(X_MIN);
  localparam logic [10:0] X_MAX11  = 11'(X_MAX);
  localparam logic [10:0] Y_MIN11  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX11  = 11'(Y_MAX);
  localparam logic [10:0] R_TOP11  = 11'(RIVER_TOP);
  localparam logic [10:0] R_BOT11  = 11'(RIVER_BOT);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [9:0]  START_X10 = 10'(START_X);
  localparam logic [9:0]  START_Y10 = 10'(START_Y);

  state_t           state_q, state_d;
  logic [9:0]       frog_x_q, frog_x_d, frog_y_q, frog_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dead_q, dead_d;
`ifdef FROG_LIVES_EN
  logic [1:0]       lives_q, lives_d;
`endif

  logic [10:0]         fx11, fy11;
  logic [NUM_LOGS-1:0] overlap;
  logic                carrier_moved;
  logic                in_river;
  logic                hop_ok;
  logic [9:0]          hop_x, hop_y;
  logic                die;

  assign fx11     = {1'b0, frog_x_q};
  assign fy11     = {1'b0, frog_y_q};
  assign in_river = (fy11 >= R_TOP11) && (fy11 <= R_BOT11);

  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_LOGS; i++) begin
      overlap[i] = (frog_y_q == logY_bus[10*i +: 10]) &&
                   (fx11 + FROG_W11 > {1'b0, logX_bus[10*i +: 10]}) &&
                   (fx11 < {1'b0, logX_bus[10*i +: 10]} + LOG_W11);
    end
  end

  // Carrier is the lowest-index overlapping log: scan downward so it is written last
  always_comb begin
    carrier_moved = 1'b0;
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      if (overlap[i]) carrier_moved = log_moved[i];
    end
  end

  // Only the highest-priority request is considered; if it is out of bounds, no hop
  always_comb begin
    hop_ok = 1'b0;
    hop_x  = frog_x_q;
    hop_y  = frog_y_q;
    if (hop_up) begin
      if (fy11 >= Y_MIN11 + STEP11) begin hop_ok = 1'b1; hop_y = frog_y_q - STEP10; end
    end else if (hop_down) begin
      if (fy11 + STEP11 <= Y_MAX11) begin hop_ok = 1'b1; hop_y = frog_y_q + STEP10; end
    end else if (hop_left) begin
      if (fx11 >= X_MIN11 + STEP11) begin hop_ok = 1'b1; hop_x = frog_x_q - STEP10; end
    end else if (hop_right) begin
      if (fx11 + STEP11 <= X_MAX11) begin hop_ok = 1'b1; hop_x = frog_x_q + STEP10; end
    end
  end

  always_comb begin
    state_d  = state_q;
    frog_x_d = frog_x_q;
    frog_y_d = frog_y_q;
    cnt_d    = cnt_q;
    dead_d   = 1'b0;
    die      = 1'b0;
`ifdef FROG_LIVES_EN
    lives_d  = lives_q;
`endif
    case (state_q)
      S_ALIVE: begin
        if (hop_ok) begin
          frog_x_d = hop_x;
          frog_y_d = hop_y;
        end else if (in_river) begin
          if (overlap == '0) begin
            die = 1'b1;
          end else if (carrier_moved) begin
            // Being pushed past the right edge kills; the log's own wrap never drags the frog
            if (fx11 + 11'd1 > X_MAX11) die = 1'b1;
            else frog_x_d = frog_x_q + 10'd1;
          end
        end
        if (die) begin
          state_d = S_DYING;
          dead_d  = 1'b1;
          cnt_d   = '0;
`ifdef FROG_LIVES_EN
          lives_d = lives_q - 2'd1;
`endif
        end
      end
      S_DYING: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef FROG_LIVES_EN
          if (lives_q == 2'd0) begin
            state_d = S_OVER;
          end else
`endif
          begin
            state_d  = S_ALIVE;
            frog_x_d = START_X10;
            frog_y_d = START_Y10;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_ALIVE;
      frog_x_q <= START_X10;
      frog_y_q <= START_Y10;
      cnt_q    <= '0;
      dead_q   <= 1'b0;
`ifdef FROG_LIVES_EN
      lives_q  <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      frog_x_q <= frog_x_d;
      frog_y_q <= frog_y_d;
      cnt_q    <= cnt_d;
      dead_q   <= dead_d;
`ifdef FROG_LIVES_EN
      lives_q  <= lives_d;
`endif
    end
  end

  assign frogX  = frog_x_q;
  assign frogY  = frog_y_q;
  assign riding = in_river && (overlap != '0);
  assign dying  = (state_q == S_DYING);
  assign dead   = dead_q;
`ifdef FROG_LIVES_EN
  assign lives     = lives_q;
  assign game_over = (state_q == S_OVER);
`else
  assign lives     = 2'd3;
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_frog_log_carry.sv
// tb/tb_frog_log_carry.sv - directed self-checking bench for frog_log_carry
module tb_frog_log_carry;

  localparam int DH = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hop_up = 0, hop_down = 0, hop_left = 0, hop_right = 0;
  logic [39:0] logX_bus, logY_bus;
  logic [3:0]  log_moved = '0;
  logic [9:0]  frogX, frogY;
  logic        riding, dying, dead, game_over;
  logic [1:0]  lives;
  logic [9:0]  lx [4];
  logic [9:0]  ly [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    logX_bus = '0;
    logY_bus = '0;
    for (int i = 0; i < 4; i++) begin
      logX_bus[10*i +: 10] = lx[i];
      logY_bus[10*i +: 10] = ly[i];
    end
  end

  frog_log_carry #(.DEATH_HOLD(DH)) dut (
    .frame_clk(clk), .Reset_n(rst_n),
    .hop_up(hop_up), .hop_down(hop_down), .hop_left(hop_left), .hop_right(hop_right),
    .logX_bus(logX_bus), .logY_bus(logY_bus), .log_moved(log_moved),
    .frogX(frogX), .frogY(frogY), .riding(riding), .dying(dying), .dead(dead),
    .lives(lives), .game_over(game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // d: 0 up, 1 down, 2 left, 3 right
  task automatic hop(input int d);
    hop_up = (d == 0); hop_down = (d == 1); hop_left = (d == 2); hop_right = (d == 3);
    tick();
    hop_up = 0; hop_down = 0; hop_left = 0; hop_right = 0;
  endtask

  // log idx advances one pixel with its moved pulse
  task automatic carry_pulse(input int idx);
    log_moved[idx] = 1'b1;
    lx[idx] = lx[idx] + 10'd1;
    tick();
    log_moved = '0;
  endtask

  task automatic park_logs();
    for (int i = 0; i < 4; i++) begin lx[i] = 10'd0; ly[i] = 10'd0; end
  endtask

  // Called on the first DYING cycle already observed (n cycles seen so far)
  task automatic wait_respawn(input int seen);
    int n = seen;
    while (dying && n < DH + 10) begin
      tick();
      if (dying) n++;
    end
    tests++; if (n !== DH) begin fails++; $display("FAIL hold_cycles: got %0d want %0d", n, DH); end
    tests++; if (dying !== 1'b0) begin fails++; $display("FAIL respawn_dying: got %0b want 0", dying); end
    tests++; if (frogX !== 10'd304 || frogY !== 10'd448) begin
      fails++; $display("FAIL respawn_pos: got (%0d,%0d) want (304,448)", frogX, frogY);
    end
  endtask

  // From start, hop up into open water at Y=224; checks the delayed death pulse
  task automatic drown();
    park_logs();
    for (int k = 0; k < 14; k++) hop(0);
    tests++; if (frogY !== 10'd224 || dead !== 1'b0) begin
      fails++; $display("FAIL drown_land: got y=%0d dead=%0b want y=224 dead=0", frogY, dead);
    end
    tick();
    tests++; if (dead !== 1'b1 || dying !== 1'b1) begin
      fails++; $display("FAIL drown_dead: got dead=%0b dying=%0b want 1 1", dead, dying);
    end
  endtask

  task automatic test_reset();
    park_logs();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (frogX !== 10'd304) begin fails++; $display("FAIL reset_x: got %0d want 304", frogX); end
    tests++; if (frogY !== 10'd448) begin fails++; $display("FAIL reset_y: got %0d want 448", frogY); end
    tests++; if (lives !== 2'd3) begin fails++; $display("FAIL reset_lives: got %0d want 3", lives); end
    tests++; if (dying !== 1'b0 || dead !== 1'b0 || game_over !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got dying=%0b dead=%0b go=%0b want 0 0 0", dying, dead, game_over);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hop();
    for (int k = 1; k <= 4; k++) begin
      hop(0);
      tests++; if (frogY !== 10'(448 - 16*k)) begin
        fails++; $display("FAIL hop_up_%0d: got %0d want %0d", k, frogY, 448 - 16*k);
      end
    end
    for (int k = 0; k < 4; k++) hop(1);
    hop(1);
    tests++; if (frogY !== 10'd448) begin fails++; $display("FAIL hop_down_edge: got %0d want 448", frogY); end
    // up beats left when both pulse
    hop_up = 1; hop_left = 1; tick(); hop_up = 0; hop_left = 0;
    tests++; if (frogY !== 10'd432 || frogX !== 10'd304) begin
      fails++; $display("FAIL hop_priority: got (%0d,%0d) want (304,432)", frogX, frogY);
    end
    hop(1);
    for (int k = 0; k < 7; k++) hop(2);
    tests++; if (frogX !== 10'd192) begin fails++; $display("FAIL hop_left: got %0d want 192", frogX); end
    // left from 175 would land at 159 (legal), from 159 to 143 is not
    hop(2); hop(2); hop(2);
    tests++; if (frogX !== 10'd160) begin fails++; $display("FAIL hop_left_edge: got %0d want 160", frogX); end
    hop(3); hop(3);
    for (int k = 0; k < 13; k++) hop(0);
    tests++; if (frogY !== 10'd240 || frogX !== 10'd192) begin
      fails++; $display("FAIL hop_to_bank: got (%0d,%0d) want (192,240)", frogX, frogY);
    end
  endtask

  task automatic test_carry();
    lx[0] = 10'd182;
    for (int k = 1; k <= 5; k++) begin
      ly[0] = 10'(240 - 16*k);
      hop(0);
    end
    tests++; if (frogY !== 10'd160 || riding !== 1'b1 || dying !== 1'b0) begin
      fails++; $display("FAIL river_entry: got y=%0d riding=%0b dying=%0b want 160 1 0", frogY, riding, dying);
    end
    for (int k = 0; k < 8; k++) carry_pulse(0);
    tests++; if (frogX !== 10'd200 || lx[0] !== 10'd190) begin
      fails++; $display("FAIL carry_setup: got x=%0d want 200", frogX);
    end
    for (int k = 1; k <= 5; k++) begin
      carry_pulse(0);
      tests++; if (frogX !== 10'(200 + k) || riding !== 1'b1) begin
        fails++; $display("FAIL carry_%0d: got x=%0d riding=%0b want %0d 1", k, frogX, riding, 200 + k);
      end
    end
    // log1 also overlaps, but log0 is the carrier; only log1 moves
    lx[1] = 10'd200; ly[1] = 10'd160;
    carry_pulse(1);
    tests++; if (frogX !== 10'd205) begin fails++; $display("FAIL carrier_priority: got %0d want 205", frogX); end
    lx[1] = 10'd0; ly[1] = 10'd0;
    // hop accepted on the same cycle drops the carry
    hop_right = 1; carry_pulse(0); hop_right = 0;
    tests++; if (frogX !== 10'd221) begin fails++; $display("FAIL hop_drops_carry: got %0d want 221", frogX); end
  endtask

  task automatic test_off_edge();
    for (int k = 0; k < 242; k++) carry_pulse(0);
    tests++; if (frogX !== 10'd463 || dying !== 1'b0) begin
      fails++; $display("FAIL carry_to_edge: got x=%0d dying=%0b want 463 0", frogX, dying);
    end
    carry_pulse(0);
    tests++; if (dead !== 1'b1 || dying !== 1'b1 || frogX !== 10'd463) begin
      fails++; $display("FAIL edge_death: got dead=%0b dying=%0b x=%0d want 1 1 463", dead, dying, frogX);
    end
    hop(1);
    tests++; if (dead !== 1'b0 || dying !== 1'b1 || frogY !== 10'd160) begin
      fails++; $display("FAIL dying_hold: got dead=%0b dying=%0b y=%0d want 0 1 160", dead, dying, frogY);
    end
    wait_respawn(2);
  endtask

  task automatic test_drown();
    drown();
    wait_respawn(1);
`ifndef FROG_LIVES_EN
    tests++; if (lives !== 2'd3 || game_over !== 1'b0) begin
      fails++; $display("FAIL infinite_lives: got lives=%0d go=%0b want 3 0", lives, game_over);
    end
`endif
  endtask

`ifdef FROG_LIVES_EN
  task automatic test_lives();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    drown();
    tests++; if (lives !== 2'd2) begin fails++; $display("FAIL lives_dec: got %0d want 2", lives); end
    tick(); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    tests++; if (dying !== 1'b0 || lives !== 2'd3 || frogY !== 10'd448) begin
      fails++; $display("FAIL reset_mid_dying: got dying=%0b lives=%0d y=%0d want 0 3 448", dying, lives, frogY);
    end
    for (int d = 2; d >= 1; d--) begin
      drown();
      tests++; if (lives !== 2'(d)) begin fails++; $display("FAIL lives_%0d: got %0d", d, lives); end
      wait_respawn(1);
    end
    drown();
    tests++; if (lives !== 2'd0) begin fails++; $display("FAIL lives_0: got %0d want 0", lives); end
    for (int k = 0; k < DH + 10 && dying; k++) tick();
    tests++; if (game_over !== 1'b1 || dying !== 1'b0) begin
      fails++; $display("FAIL game_over: got go=%0b dying=%0b want 1 0", game_over, dying);
    end
    hop(1);
    tests++; if (frogY !== 10'd224 || game_over !== 1'b1) begin
      fails++; $display("FAIL over_ignores_hop: got y=%0d go=%0b want 224 1", frogY, game_over);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    tests++; if (game_over !== 1'b0 || lives !== 2'd3) begin
      fails++; $display("FAIL over_reset: got go=%0b lives=%0d want 0 3", game_over, lives);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hop();
    test_carry();
    test_off_edge();
    test_drown();
`ifdef FROG_LIVES_EN
    test_lives();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
